// File: rtl/pe_load_sequencer_if.sv
// Bundle of streaming-source, PE-load and control signals between the
// load sequencer (master side) and the global buffer / PE (slave side).
interface pe_load_sequencer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  start;
    logic [CNT_WIDTH-1:0]  w_len;
    logic [CNT_WIDTH-1:0]  f_len;
    logic [CNT_WIDTH-1:0]  n_seg;

    logic [DATA_WIDTH-1:0] w_src_data;
    logic                  w_src_valid;
    logic                  w_src_ready;
    logic [DATA_WIDTH-1:0] f_src_data;
    logic                  f_src_valid;
    logic                  f_src_ready;

    logic                  fifo_full_filter;
    logic                  fifo_full_fmap;
    logic                  shift_finish_flg;

    logic                  start_config;
    logic                  start_weight_load;
    logic                  start_feature_load;
    logic                  load_full_cloumn;
    logic [DATA_WIDTH-1:0] weight_in;
    logic                  weight_in_en;
    logic [DATA_WIDTH-1:0] feature_in;
    logic                  feature_in_en;

    logic                  busy;
    logic [CNT_WIDTH-1:0]  seg_idx;
    logic                  done;

    modport master (
        input  start, w_len, f_len, n_seg,
        input  w_src_data, w_src_valid, f_src_data, f_src_valid,
        input  fifo_full_filter, fifo_full_fmap, shift_finish_flg,
        output w_src_ready, f_src_ready,
        output start_config, start_weight_load, start_feature_load, load_full_cloumn,
        output weight_in, weight_in_en, feature_in, feature_in_en,
        output busy, seg_idx, done
    );

    modport slave (
        output start, w_len, f_len, n_seg,
        output w_src_data, w_src_valid, f_src_data, f_src_valid,
        output fifo_full_filter, fifo_full_fmap, shift_finish_flg,
        input  w_src_ready, f_src_ready,
        input  start_config, start_weight_load, start_feature_load, load_full_cloumn,
        input  weight_in, weight_in_en, feature_in, feature_in_en,
        input  busy, seg_idx, done
    );
endinterface

// File: rtl/pe_load_sequencer.sv
// Drives one PE through config, concurrent weight + first fmap column load,
// then further fmap segments, each released by the PE's shift_finish_flg.
module pe_load_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                clk,
    input  logic                rst,
    pe_load_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CFG,
        S_LSTART,
        S_LOAD,
        S_WSHIFT,
        S_SSTART,
        S_FLOAD,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t               state_q;
    logic [CNT_WIDTH-1:0] w_len_q;
    logic [CNT_WIDTH-1:0] f_len_q;
    logic [CNT_WIDTH-1:0] n_seg_q;
    logic [CNT_WIDTH-1:0] w_cnt_q;
    logic [CNT_WIDTH-1:0] f_cnt_q;
    logic [CNT_WIDTH-1:0] seg_idx_q;
    logic                 start_config_q;
    logic                 start_weight_load_q;
    logic                 start_feature_load_q;
    logic                 load_full_cloumn_q;
    logic                 done_q;

    logic [CNT_WIDTH-1:0]  w_cnt_d;
    logic [CNT_WIDTH-1:0]  f_cnt_d;
    logic                  w_ready;
    logic                  f_ready;
    logic                  w_complete;
    logic                  f_complete;
    logic                  last_seg;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] f_data;

    // A ready is a completed transfer: the source has a word, the PE FIFO has
    // room and the configured length has not been reached yet.
    always_comb begin
        w_ready = 1'b0;
        f_ready = 1'b0;
        w_ready = (state_q == S_LOAD) && (w_cnt_q != w_len_q)
                  && bus.w_src_valid && !bus.fifo_full_filter;
        f_ready = ((state_q == S_LOAD) || (state_q == S_FLOAD)) && (f_cnt_q != f_len_q)
                  && bus.f_src_valid && !bus.fifo_full_fmap;
    end

    // Exit decisions look at the post-transfer count so the state advances on
    // the same edge that moves the final word.
    always_comb begin
        w_cnt_d    = w_cnt_q;
        f_cnt_d    = f_cnt_q;
        if (w_ready) begin
            w_cnt_d = w_cnt_q + CNT_ONE;
        end
        if (f_ready) begin
            f_cnt_d = f_cnt_q + CNT_ONE;
        end
        w_complete = (w_cnt_d == w_len_q);
        f_complete = (f_cnt_d == f_len_q);
        last_seg   = ((seg_idx_q + CNT_ONE) == n_seg_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q              <= S_IDLE;
            w_len_q              <= CNT_ZERO;
            f_len_q              <= CNT_ZERO;
            n_seg_q              <= CNT_ZERO;
            w_cnt_q              <= CNT_ZERO;
            f_cnt_q              <= CNT_ZERO;
            seg_idx_q            <= CNT_ZERO;
            start_config_q       <= 1'b0;
            start_weight_load_q  <= 1'b0;
            start_feature_load_q <= 1'b0;
            load_full_cloumn_q   <= 1'b0;
            done_q               <= 1'b0;
        end else begin
            start_config_q       <= 1'b0;
            start_weight_load_q  <= 1'b0;
            start_feature_load_q <= 1'b0;
            done_q               <= 1'b0;
            w_cnt_q              <= w_cnt_d;
            f_cnt_q              <= f_cnt_d;

            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        w_len_q        <= bus.w_len;
                        f_len_q        <= bus.f_len;
                        n_seg_q        <= (bus.n_seg == CNT_ZERO) ? CNT_ONE : bus.n_seg;
                        w_cnt_q        <= CNT_ZERO;
                        f_cnt_q        <= CNT_ZERO;
                        seg_idx_q      <= CNT_ZERO;
                        start_config_q <= 1'b1;
                        state_q        <= S_CFG;
                    end
                end
                S_CFG: begin
                    start_weight_load_q  <= 1'b1;
                    start_feature_load_q <= 1'b1;
                    load_full_cloumn_q   <= 1'b1;
                    state_q              <= S_LSTART;
                end
                S_LSTART: begin
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    if (w_complete && f_complete) begin
                        state_q <= S_WSHIFT;
                    end
                end
                S_WSHIFT: begin
                    if (bus.shift_finish_flg) begin
                        if (last_seg) begin
                            done_q             <= 1'b1;
                            load_full_cloumn_q <= 1'b0;
                            state_q            <= S_DONE;
                        end else begin
                            seg_idx_q            <= seg_idx_q + CNT_ONE;
                            start_feature_load_q <= 1'b1;
                            state_q              <= S_SSTART;
                        end
                    end
                end
                S_SSTART: begin
                    f_cnt_q <= CNT_ZERO;
                    state_q <= S_FLOAD;
                end
                S_FLOAD: begin
                    if (f_complete) begin
                        state_q <= S_WSHIFT;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign w_data = bus.w_src_data;
    assign f_data = bus.f_src_data;

    assign bus.w_src_ready        = w_ready;
    assign bus.f_src_ready        = f_ready;
    assign bus.weight_in          = w_data;
    assign bus.weight_in_en       = w_ready;
    assign bus.feature_in         = f_data;
    assign bus.feature_in_en      = f_ready;
    assign bus.start_config       = start_config_q;
    assign bus.start_weight_load  = start_weight_load_q;
    assign bus.start_feature_load = start_feature_load_q;
    assign bus.load_full_cloumn   = load_full_cloumn_q;
    assign bus.busy               = (state_q != S_IDLE);
    assign bus.seg_idx            = seg_idx_q;
    assign bus.done               = done_q;

endmodule

// File: tb/tb_pe_load_sequencer.sv
// Self-checking bench: table of load schedules with a PE/source model and a
// word-order scoreboard, plus hand-written start-timing and mid-run reset checks.
module tb_pe_load_sequencer;

    logic clk;
    logic rst;

    pe_load_sequencer_if #(.DATA_WIDTH(16), .CNT_WIDTH(16)) bus ();

    pe_load_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        int    w_len;
        int    f_len;
        int    n_seg;
        int    bp_mode;
        bit    gap;
        bit    early;
        bit    busy_start;
        int    exp_w;
        int    exp_f;
        int    exp_sfl;
    } vec_t;

    vec_t  vecs [7];
    int    checks   = 0;
    int    failures = 0;
    string cur_case = "init";
    int    w_exp [$];
    int    f_exp [$];

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s/%s actual=%0d expected=%0d", cur_case, name, act, exp);
        end
    endtask

    task automatic drive_idle();
        bus.start            = 1'b0;
        bus.w_len            = 16'd0;
        bus.f_len            = 16'd0;
        bus.n_seg            = 16'd0;
        bus.w_src_data       = 16'd0;
        bus.w_src_valid      = 1'b0;
        bus.f_src_data       = 16'd0;
        bus.f_src_valid      = 1'b0;
        bus.fifo_full_filter = 1'b0;
        bus.fifo_full_fmap   = 1'b0;
        bus.shift_finish_flg = 1'b0;
    endtask

    task automatic run_case(input vec_t v);
        int cycle, w_next, f_next, wcnt, fcnt, fseg;
        int sfl_cnt, done_cnt, cfg_cnt, swl_cnt;
        int countdown, last_shift, gap_left, done_cycle;
        bit shifted, gap_used, finished, w_acc, f_acc;
        cur_case = v.name;
        w_exp.delete();
        f_exp.delete();
        for (int i = 1; i <= v.exp_w; i++) w_exp.push_back(i);
        for (int i = 1; i <= v.exp_f; i++) f_exp.push_back(i);
        w_next = 1; f_next = 1; wcnt = 0; fcnt = 0; fseg = 0;
        sfl_cnt = 0; done_cnt = 0; cfg_cnt = 0; swl_cnt = 0;
        countdown = -1; last_shift = -100; gap_left = 0; done_cycle = -1;
        shifted = 1'b0; gap_used = 1'b0; finished = 1'b0;

        bus.w_len = 16'(v.w_len);
        bus.f_len = 16'(v.f_len);
        bus.n_seg = 16'(v.n_seg);
        bus.start = 1'b1;
        @(posedge clk); #1;
        cycle = 1;
        while (!finished && cycle < 3000) begin
            bus.start = 1'b0;
            bus.w_len = 16'(v.w_len);
            bus.f_len = 16'(v.f_len);
            bus.n_seg = 16'(v.n_seg);
            if (v.busy_start && cycle == 10) begin
                bus.start = 1'b1;
                bus.w_len = 16'd7;
                bus.f_len = 16'd3;
                bus.n_seg = 16'd1;
            end
            bus.w_src_valid      = 1'b1;
            bus.f_src_valid      = 1'b1;
            bus.fifo_full_filter = 1'b0;
            bus.fifo_full_fmap   = 1'b0;
            if (v.bp_mode == 1) begin
                bus.fifo_full_filter = (cycle % 3) != 0;
                bus.fifo_full_fmap   = (cycle % 3) != 1;
            end else if (v.bp_mode == 2) begin
                bus.w_src_valid      = cycle[0];
                bus.f_src_valid      = !cycle[0];
                bus.fifo_full_filter = (cycle % 4) == 1;
                bus.fifo_full_fmap   = (cycle % 3) == 0;
            end
            if (gap_left > 0) begin
                bus.f_src_valid = 1'b0;
                gap_left--;
            end
            bus.shift_finish_flg = 1'b0;
            if (countdown == 0) begin
                bus.shift_finish_flg = 1'b1;
                shifted    = 1'b1;
                last_shift = cycle;
                countdown  = -1;
            end else if (countdown > 0) begin
                countdown--;
            end
            if (v.early && cycle == 6) bus.shift_finish_flg = 1'b1;
            bus.w_src_data = 16'(w_next);
            bus.f_src_data = 16'(f_next);

            @(negedge clk);
            w_acc = bus.weight_in_en;
            f_acc = bus.feature_in_en;
            if (bus.start_config) begin
                cfg_cnt++;
                check_eq("cfg_cycle", cycle, 1);
            end
            if (bus.start_weight_load) begin
                swl_cnt++;
                check_eq("wload_cycle", cycle, 2);
            end
            if (bus.start_feature_load) begin
                sfl_cnt++;
                fseg    = 0;
                shifted = 1'b0;
                if (sfl_cnt == 1) check_eq("fload1_cycle", cycle, 2);
                else              check_eq("fload_after_shift", cycle - last_shift, 1);
            end
            if (cycle == 2) check_eq("lfc_rise", bus.load_full_cloumn, 1);
            if (cycle == 3 && v.bp_mode == 0 && v.w_len > 0)
                check_eq("first_xfer_cycle3", bus.weight_in_en, 1);
            if (w_acc) begin
                check_eq("w_en_legal", bus.w_src_valid && !bus.fifo_full_filter, 1);
                check_eq("w_pass", bus.weight_in, bus.w_src_data);
                if (w_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s/w_extra actual=%0d expected=no_word", cur_case, bus.weight_in);
                end else begin
                    check_eq("w_order", bus.weight_in, w_exp.pop_front());
                end
                wcnt++;
            end
            if (f_acc) begin
                check_eq("f_en_legal", bus.f_src_valid && !bus.fifo_full_fmap, 1);
                check_eq("f_pass", bus.feature_in, bus.f_src_data);
                if (f_exp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL %s/f_extra actual=%0d expected=no_word", cur_case, bus.feature_in);
                end else begin
                    check_eq("f_order", bus.feature_in, f_exp.pop_front());
                end
                fcnt++;
                fseg++;
                if (v.gap && !gap_used && fcnt == 6) begin
                    gap_used = 1'b1;
                    gap_left = 20;
                end
            end
            if (done_cycle >= 0) begin
                check_eq("busy_after_done", bus.busy, 0);
                check_eq("lfc_after_done", bus.load_full_cloumn, 0);
                finished = 1'b1;
            end
            if (bus.done) begin
                done_cnt++;
                check_eq("done_after_shift", cycle - last_shift, 1);
                check_eq("busy_in_done", bus.busy, 1);
                done_cycle = cycle;
            end
            // PE model: finish shifting a few cycles after the column is fully loaded.
            if (!shifted && countdown < 0 && sfl_cnt > 0 && fseg == v.f_len
                && (sfl_cnt > 1 || wcnt == v.w_len))
                countdown = 2;
            @(posedge clk); #1;
            if (w_acc) w_next++;
            if (f_acc) f_next++;
            cycle++;
        end
        drive_idle();
        check_eq("completed", finished, 1);
        check_eq("w_count", wcnt, v.exp_w);
        check_eq("f_count", fcnt, v.exp_f);
        check_eq("fload_pulses", sfl_cnt, v.exp_sfl);
        check_eq("cfg_pulses", cfg_cnt, 1);
        check_eq("wload_pulses", swl_cnt, 1);
        check_eq("done_pulses", done_cnt, 1);
        check_eq("w_left", w_exp.size(), 0);
        check_eq("f_left", f_exp.size(), 0);
        $display("case %s: w=%0d f=%0d fload=%0d done=%0d cycles=%0d",
                 v.name, wcnt, fcnt, sfl_cnt, done_cnt, cycle);
    endtask

    initial begin
        int wcount;
        vecs[0] = '{"baseline",   102, 12, 3, 0, 1'b0, 1'b0, 1'b1, 102, 36, 3};
        vecs[1] = '{"backpress",  102, 12, 3, 1, 1'b0, 1'b0, 1'b1, 102, 36, 3};
        vecs[2] = '{"src_gap",     20, 12, 1, 0, 1'b1, 1'b0, 1'b0,  20, 12, 1};
        vecs[3] = '{"early_shift", 40,  8, 2, 0, 1'b0, 1'b1, 1'b1,  40, 16, 2};
        vecs[4] = '{"degenerate",   0,  4, 0, 0, 1'b0, 1'b0, 1'b0,   0,  4, 1};
        vecs[5] = '{"toggle",      30,  5, 4, 2, 1'b0, 1'b0, 1'b1,  30, 20, 4};
        vecs[6] = '{"f_len_zero",   5,  0, 2, 0, 1'b0, 1'b0, 1'b0,   5,  0, 2};

        // Reset state, with sources offering words so the readies are meaningful.
        cur_case = "reset";
        drive_idle();
        bus.w_src_valid = 1'b1;
        bus.f_src_valid = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("busy", bus.busy, 0);
        check_eq("start_config", bus.start_config, 0);
        check_eq("start_weight_load", bus.start_weight_load, 0);
        check_eq("start_feature_load", bus.start_feature_load, 0);
        check_eq("load_full_cloumn", bus.load_full_cloumn, 0);
        check_eq("done", bus.done, 0);
        check_eq("seg_idx", bus.seg_idx, 0);
        check_eq("w_src_ready", bus.w_src_ready, 0);
        check_eq("f_src_ready", bus.f_src_ready, 0);
        rst = 1'b1;

        // Start timing, start-while-busy, then reset during segment-2 FLOAD.
        cur_case = "hand_reset";
        bus.w_src_data = 16'h1234;
        bus.f_src_data = 16'h0abc;
        bus.w_len = 16'd4;
        bus.f_len = 16'd3;
        bus.n_seg = 16'd3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check_eq("cfg_c1", bus.start_config, 1);
        check_eq("wload_c1", bus.start_weight_load, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("cfg_c2", bus.start_config, 0);
        check_eq("wload_c2", bus.start_weight_load, 1);
        check_eq("fload_c2", bus.start_feature_load, 1);
        check_eq("lfc_c2", bus.load_full_cloumn, 1);
        check_eq("busy_c2", bus.busy, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("w_en_c3", bus.weight_in_en, 1);
        check_eq("f_en_c3", bus.feature_in_en, 1);
        check_eq("w_data_c3", bus.weight_in, 16'h1234);
        check_eq("f_data_c3", bus.feature_in, 16'h0abc);
        wcount = 1;
        #2;
        bus.start = 1'b1;
        bus.w_len = 16'd50;
        for (int c = 4; c <= 8; c++) begin
            @(posedge clk); #1;
            bus.start = 1'b0;
            bus.w_len = 16'd4;
            bus.shift_finish_flg = (c == 8);
            @(negedge clk);
            if (bus.weight_in_en) wcount++;
        end
        check_eq("w_words_seg0", wcount, 4);
        @(posedge clk); #1;
        bus.shift_finish_flg = 1'b0;
        bus.f_src_valid = 1'b0;
        @(negedge clk);
        check_eq("fload_seg1", bus.start_feature_load, 1);
        check_eq("seg_idx_1", bus.seg_idx, 1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("busy_fload", bus.busy, 1);
        check_eq("lfc_fload", bus.load_full_cloumn, 1);
        check_eq("f_ready_stalled", bus.f_src_ready, 0);
        #2;
        bus.f_src_valid = 1'b1;
        #1;
        check_eq("f_ready_fload", bus.f_src_ready, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_busy", bus.busy, 0);
        check_eq("rst_seg_idx", bus.seg_idx, 0);
        check_eq("rst_lfc", bus.load_full_cloumn, 0);
        check_eq("rst_f_ready", bus.f_src_ready, 0);
        check_eq("rst_f_en", bus.feature_in_en, 0);
        check_eq("rst_w_en", bus.weight_in_en, 0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("rst_no_done", bus.done, 0);
        end
        rst = 1'b1;
        drive_idle();
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_case(vecs[i]);
            repeat (2) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
